fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch between the PC and instruction memory; sits ahead of instruction decode.
//  Issues one word request at a time, buffers returned words in a small prefetch queue, and presents
//  {instr, instr_pc} to decode under a valid/stall handshake.
//  Redirects from branch resolution flush the queue. A response already in flight is dropped on return.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address loaded on reset (bits[1:0] forced to 0)
//  QDEPTH    2              prefetch queue entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  reset        in   1   synchronous, active-low reset
//  im_req       out  1   one-cycle request strobe to instruction memory
//  im_addr      out  32  word-aligned request address, valid while im_req=1
//  im_ack       in   1   response strobe for the single outstanding request
//  im_data      in   32  instruction word, valid while im_ack=1
//  redirect     in   1   branch taken; flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address (bits[1:0] ignored, forced 0)
//  stall        in   1   decode cannot accept this cycle
//  halt         in   1   stop issuing new requests (level)
//  instr_valid  out  1   queue head valid
//  instr        out  32  queue head instruction
//  instr_pc     out  32  address the head instruction was fetched from
//  pc           out  32  next fetch address
//  busy         out  1   request outstanding (state WAIT or DRAIN)
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE, pc=RESET_PC&~3, queue empty.
//   Outputs: im_req=0, instr_valid=0, busy=0. im_addr, instr, instr_pc=0.
//  States:
//   IDLE: -> REQ when !halt.
//   REQ:  assert im_req with im_addr=pc.
//         -> WAIT if at least one queue slot is free, ignoring the entry the request will fill;
//            otherwise hold in REQ with im_req=0.
//   WAIT: on im_ack: push {im_data, pc}, pc<=pc+4. Then -> REQ if !halt, else -> IDLE.
//   DRAIN: on im_ack: discard data, pc unchanged. Then -> REQ if !halt, else -> IDLE.
//  Latency/throughput:
//   im_req at cycle N; im_ack earliest N+1; instr_valid earliest N+2 (registered queue).
//   Peak rate is one word per 2 cycles.
//  Pop rule: the head retires when instr_valid && !stall. Push and pop may occur in the same cycle,
//   including when the queue is full. Credit counting ensures a push never overflows.
//  Redirect (highest priority):
//   - Queue flushed the same cycle; instr_valid=0 the next cycle.
//   - pc<=redirect_pc&~3.
//   - If in WAIT -> DRAIN; a same-cycle im_ack is discarded. Otherwise -> REQ if !halt, else IDLE.
//   - No im_req in the redirect cycle.
//  Halt: never aborts an outstanding request. The queue keeps draining to decode. pc holds.
//   Redirect during halt updates pc and stays IDLE.
//  pc arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
//  im_ack in IDLE/REQ is a protocol error and is ignored.
//  Reset mid-operation: the in-flight response is abandoned. Memory must not ack after reset.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds two outputs.
//   perf_fetch_cnt  out 32: +1 per word pushed.
//   perf_flush_cnt  out 32: +1 per redirect cycle.
//   Both 0 on reset; both wrap.
//  FETCH_PERF_CNT_EN undefined: these ports and their counters do not exist.
// TESTING
//  Reset release, 1-cycle-latency memory, stall=0:
//   -> im_addr 0,4,8,... every 2nd cycle; instr_pc matches each im_addr.
//  stall=1 held for 10 cycles:
//   -> exactly QDEPTH words queued, no further im_req; stall=0 -> words emerge in order, none lost.
//  redirect=1, redirect_pc=32'h0000_0103, while WAIT:
//   -> late ack discarded; next im_addr=32'h100; next instr_pc=32'h100.
//  halt=1 while WAIT:
//   -> ack accepted, state IDLE, no im_req.
//   -> redirect to 32'h40 while halted, then halt=0: im_addr=32'h40.
//  pc=32'hFFFF_FFFC fetched:
//   -> next im_addr=32'h0.
//  FETCH_PERF_CNT_EN: 5 fetches then 1 redirect -> perf_fetch_cnt=5, perf_flush_cnt=1.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, prefetch queue, redirect flush.
// Optional perf counters (perf_fetch_cnt, perf_flush_cnt) when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        halt,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t        state;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          credit, push, pop;

    // A request is only issued when its word is guaranteed a slot; with a single
    // outstanding request, occupancy can only fall before the response returns.
    assign credit = (count < QFULL);
    assign push   = (state == WAIT) && im_ack && !redirect;
    assign pop    = instr_valid && !stall && !redirect;

    assign im_req      = (state == REQ) && credit && !redirect;
    assign im_addr     = im_req ? pc : 32'h0;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_instr[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr]    : 32'h0;
    assign busy        = (state == WAIT) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= im_data;
            q_pc[wr_ptr]    <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= RESET_PC & ~32'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= redirect_pc & ~32'h3;
            // An un-returned request must be drained so its late ack is not taken as new data.
            if ((state == WAIT || state == DRAIN) && !im_ack)
                state <= DRAIN;
            else
                state <= halt ? IDLE : REQ;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            case (state)
                IDLE:  if (!halt) state <= REQ;
                REQ:   if (credit) state <= WAIT;
                WAIT:  if (im_ack) begin
                           pc    <= pc + 32'd4;
                           state <= halt ? IDLE : REQ;
                       end
                DRAIN: if (im_ack) state <= halt ? IDLE : REQ;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (push)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, then random traffic against a stream-level model.
module tb_fetch_sequencer;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        im_req, im_ack;
    logic [31:0] im_addr, im_data;
    logic        redirect, stall, halt;
    logic [31:0] redirect_pc;
    logic        instr_valid, busy;
    logic [31:0] instr, instr_pc, pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_data(im_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .halt(halt),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .pc(pc), .busy(busy)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;   logic [31:0] data;
        logic        redir; logic [31:0] rpc;
        logic        stl;   logic        hlt;
        logic        e_req; logic [31:0] e_addr;
        logic        e_vld; logic [31:0] e_instr; logic [31:0] e_ipc;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic [31:0] d, input logic r, input logic [31:0] rp,
                                input logic s, input logic h, input logic eq, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep, input logic eb);
        vec_t v;
        v.ack = a; v.data = d; v.redir = r; v.rpc = rp; v.stl = s; v.hlt = h;
        v.e_req = eq; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_ipc = ep; v.e_busy = eb;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b0; im_ack = 1'b0; im_data = 32'h0; redirect = 1'b0;
        redirect_pc = 32'h0; stall = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    vec_t tbl[23];

    // Stream-level model state
    logic [31:0] exp_pc, req_exp, out_addr;
    int          mcount, lat, pops;
    bit          outst, stale, acc, pp;

    initial begin
        do_reset();
        check("reset im_req", 32'(im_req), 32'h0);
        check("reset im_addr", im_addr, 32'h0);
        check("reset instr_valid", 32'(instr_valid), 32'h0);
        check("reset instr", instr, 32'h0);
        check("reset instr_pc", instr_pc, 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset pc", pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("reset perf_fetch", perf_fetch_cnt, 32'h0);
        check("reset perf_flush", perf_flush_cnt, 32'h0);
`endif

        //            ack data                    rdr rpc            stl hlt  req addr          vld instr                ipc           busy
        tbl[0]  = mk(0, 32'h0,                  0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        0);
        tbl[1]  = mk(0, 32'h0,                  0, 32'h0,          0, 0,  1, 32'h0,         0, 32'h0,                32'h0,        0);
        tbl[2]  = mk(1, mem_word(32'h0),        0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        1);
        tbl[3]  = mk(0, 32'h0,                  0, 32'h0,          1, 0,  1, 32'h4,         1, mem_word(32'h0),      32'h0,        0);
        tbl[4]  = mk(1, mem_word(32'h4),        0, 32'h0,          1, 0,  0, 32'h0,         1, mem_word(32'h0),      32'h0,        1);
        tbl[5]  = mk(0, 32'h0,                  0, 32'h0,          1, 0,  0, 32'h0,         1, mem_word(32'h0),      32'h0,        0);
        tbl[6]  = mk(0, 32'h0,                  0, 32'h0,          1, 0,  0, 32'h0,         1, mem_word(32'h0),      32'h0,        0);
        tbl[7]  = mk(0, 32'h0,                  0, 32'h0,          0, 0,  0, 32'h0,         1, mem_word(32'h0),      32'h0,        0);
        tbl[8]  = mk(0, 32'h0,                  0, 32'h0,          1, 0,  1, 32'h8,         1, mem_word(32'h4),      32'h4,        0);
        tbl[9]  = mk(0, 32'h0,                  1, 32'h0000_0103,  1, 0,  0, 32'h0,         1, mem_word(32'h4),      32'h4,        1);
        tbl[10] = mk(1, 32'hDEAD_BEEF,          0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        1);
        tbl[11] = mk(0, 32'h0,                  0, 32'h0,          0, 0,  1, 32'h100,       0, 32'h0,                32'h0,        0);
        tbl[12] = mk(1, mem_word(32'h100),      0, 32'h0,          0, 1,  0, 32'h0,         0, 32'h0,                32'h0,        1);
        tbl[13] = mk(0, 32'h0,                  0, 32'h0,          0, 1,  0, 32'h0,         1, mem_word(32'h100),    32'h100,      0);
        tbl[14] = mk(0, 32'h0,                  1, 32'h40,         0, 1,  0, 32'h0,         0, 32'h0,                32'h0,        0);
        tbl[15] = mk(0, 32'h0,                  0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        0);
        tbl[16] = mk(0, 32'h0,                  0, 32'h0,          0, 0,  1, 32'h40,        0, 32'h0,                32'h0,        0);
        tbl[17] = mk(1, mem_word(32'h40),       0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        1);
        tbl[18] = mk(0, 32'h0,                  1, 32'hFFFF_FFFE,  0, 0,  0, 32'h0,         1, mem_word(32'h40),     32'h40,       0);
        tbl[19] = mk(0, 32'h0,                  0, 32'h0,          0, 0,  1, 32'hFFFF_FFFC, 0, 32'h0,                32'h0,        0);
        tbl[20] = mk(1, mem_word(32'hFFFF_FFFC),0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        1);
        tbl[21] = mk(0, 32'h0,                  0, 32'h0,          0, 0,  1, 32'h0,         1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0);
        tbl[22] = mk(0, 32'h0,                  0, 32'h0,          0, 0,  0, 32'h0,         0, 32'h0,                32'h0,        1);

        for (int i = 0; i < 23; i++) begin
            bit ok;
            @(negedge clk);
            reset = 1'b1;
            im_ack = tbl[i].ack; im_data = tbl[i].data; redirect = tbl[i].redir;
            redirect_pc = tbl[i].rpc; stall = tbl[i].stl; halt = tbl[i].hlt;
            #1;
            ok = (im_req === tbl[i].e_req) && (busy === tbl[i].e_busy) && (instr_valid === tbl[i].e_vld)
                 && (!tbl[i].e_req || im_addr === tbl[i].e_addr)
                 && (!tbl[i].e_vld || (instr === tbl[i].e_instr && instr_pc === tbl[i].e_ipc));
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL vec%0d: got req=%b addr=%h vld=%b instr=%h ipc=%h busy=%b expected req=%b addr=%h vld=%b instr=%h ipc=%h busy=%b",
                         i, im_req, im_addr, instr_valid, instr, instr_pc, busy,
                         tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_busy);
            end
        end
        @(negedge clk);
        im_ack = 1'b0; redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
        check("perf_flush_cnt", perf_flush_cnt, 32'd3);
`endif

        // Random traffic; memory answers the single outstanding request after 1..3 cycles.
        do_reset();
        reset = 1'b1;
        exp_pc = 32'h0; req_exp = 32'h0; mcount = 0; outst = 0; stale = 0; lat = 0; pops = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            im_ack = 1'b0; im_data = 32'h0;
            if (outst) begin
                lat--;
                if (lat == 0) begin
                    im_ack = 1'b1;
                    im_data = stale ? 32'hBAD0_BAD0 : mem_word(out_addr);
                end
            end
            stall = ($urandom % 3) == 0;
            halt = ($urandom % 12) == 0;
            redirect = ($urandom % 30) == 0;
            redirect_pc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
            #1;
            check("rnd instr_valid", 32'(instr_valid), 32'(mcount > 0));
            check("rnd busy", 32'(busy), 32'(outst));
            check("rnd pc", pc, req_exp);
            if (mcount > 0) begin
                check("rnd instr_pc", instr_pc, exp_pc);
                check("rnd instr", instr, mem_word(exp_pc));
            end
            if (im_req) begin
                check("rnd req while busy", 32'(outst), 32'h0);
                check("rnd req in redirect", 32'(redirect), 32'h0);
                check("rnd im_addr", im_addr, req_exp);
            end
            acc = im_ack && outst && !stale && !redirect;
            pp  = (mcount > 0) && !stall && !redirect;
            if (redirect) begin
                mcount = 0;
                exp_pc = redirect_pc & ~32'h3;
                req_exp = redirect_pc & ~32'h3;
                if (outst && !im_ack) stale = 1;
            end else begin
                if (pp) begin exp_pc += 32'd4; pops++; end
                if (acc) req_exp = out_addr + 32'd4;
                mcount = mcount + int'(acc) - int'(pp);
                if (mcount > QD) begin
                    check("rnd queue overflow", 32'(mcount), 32'(QD));
                    mcount = QD;
                end
            end
            if (im_ack) begin outst = 0; stale = 0; end
            if (im_req) begin
                outst = 1; out_addr = im_addr; lat = int'($urandom_range(1, 3));
            end
        end
        check("rnd progress", 32'(pops > 300), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
